// File: rtl/alu_pipe.sv
// Handshaked ALU with IDLE/BUSY/DONE control and registered result/flags.
// Define ALU_PIPE_MUL_EN to build the iterative shift-add multiplier (opcode 9).
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Neg,
    output logic             Ovf,
    output logic             Err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_n;
    logic   accept;
    logic   mul_start;
    logic   mul_last;

    assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    // ---- stage p0: single-cycle combinational evaluation of the request
    logic signed [WIDTH-1:0] a_s, b_s, r_s;
    logic        [WIDTH:0]   sum_p0;
    logic        [WIDTH:0]   shl_p0;
    logic        [WIDTH:0]   shr_p0;
    logic signed [WIDTH:0]   sar_p0;
    logic        [WIDTH-1:0] res_p0;
    logic                    cy_p0, ov_p0, err_p0;
    int                      shamt;

    assign a_s = $signed(A);
    assign b_s = $signed(B);
    assign r_s = $signed(res_p0);

    always_comb begin
        shamt  = int'(B % WIDTH);
        sum_p0 = '0;
        shl_p0 = {1'b0, A} << shamt;
        shr_p0 = {A, 1'b0} >> shamt;
        sar_p0 = $signed({A, 1'b0}) >>> shamt;
        res_p0 = '0;
        cy_p0  = 1'b0;
        ov_p0  = 1'b0;
        err_p0 = 1'b0;
        case (ALUOp)
            4'd0: begin
                sum_p0 = {1'b0, A} + {1'b0, B};
                res_p0 = sum_p0[WIDTH-1:0];
                cy_p0  = sum_p0[WIDTH];
                ov_p0  = ((a_s < 0) == (b_s < 0)) && ((r_s < 0) != (a_s < 0));
            end
            4'd1: begin
                // The extra top bit of the difference is the unsigned borrow.
                sum_p0 = {1'b0, A} - {1'b0, B};
                res_p0 = sum_p0[WIDTH-1:0];
                cy_p0  = sum_p0[WIDTH];
                ov_p0  = ((a_s < 0) != (b_s < 0)) && ((r_s < 0) != (a_s < 0));
            end
            4'd2: res_p0 = A & B;
            4'd3: res_p0 = A | B;
            4'd4: res_p0 = A ^ B;
            4'd5: res_p0 = ~A;
            4'd6: begin
                res_p0 = shl_p0[WIDTH-1:0];
                cy_p0  = shl_p0[WIDTH];
            end
            4'd7: begin
                res_p0 = shr_p0[WIDTH:1];
                cy_p0  = shr_p0[0];
            end
            4'd8: begin
                res_p0 = sar_p0[WIDTH:1];
                cy_p0  = sar_p0[0];
            end
            default: err_p0 = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    // ---- stage p1: iterative multiplier, one multiplier bit per BUSY cycle
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_p1, mcand_p1, acc_sum;
    logic [WIDTH-1:0]   mplier_p1;
    logic [CW-1:0]      cnt_p1;

    assign mul_start = accept && (ALUOp == 4'd9);
    assign mul_last  = (state == BUSY) && (cnt_p1 == CW'(WIDTH - 1));
    assign acc_sum   = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);

    always_ff @(posedge clk) begin
        if (mul_start) begin
            acc_p1    <= '0;
            mcand_p1  <= {{WIDTH{1'b0}}, A};
            mplier_p1 <= B;
            cnt_p1    <= '0;
        end else if (state == BUSY) begin
            acc_p1    <= acc_sum;
            mcand_p1  <= mcand_p1 << 1;
            mplier_p1 <= mplier_p1 >> 1;
            cnt_p1    <= cnt_p1 + 1'b1;
        end
    end
`else
    assign mul_start = 1'b0;
    assign mul_last  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = mul_start ? BUSY : DONE;
            BUSY: if (mul_last) state_n = DONE;
            DONE: begin
                if (out_ready) begin
                    if (accept) state_n = mul_start ? BUSY : DONE;
                    else        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ---- stage p2: registered result and flags, held until replaced
    always_ff @(posedge clk) begin
        if (rst) begin
            Result <= '0;
            Zero   <= 1'b0;
            Carry  <= 1'b0;
            Neg    <= 1'b0;
            Ovf    <= 1'b0;
            Err    <= 1'b0;
        end else if (accept && !mul_start) begin
            Result <= res_p0;
            Zero   <= (res_p0 == '0);
            Carry  <= cy_p0;
            Neg    <= res_p0[WIDTH-1];
            Ovf    <= ov_p0;
            Err    <= err_p0;
        end
`ifdef ALU_PIPE_MUL_EN
        else if (mul_last) begin
            Result <= acc_sum[WIDTH-1:0];
            Zero   <= (acc_sum[WIDTH-1:0] == '0);
            Carry  <= |acc_sum[2*WIDTH-1:WIDTH];
            Neg    <= acc_sum[WIDTH-1];
            Ovf    <= 1'b0;
            Err    <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): directed vectors, queued expectations,
// monitor pops on every out_valid/out_ready handshake.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A, B;
    logic [3:0] ALUOp;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Result;
    logic       Zero, Carry, Neg, Ovf, Err;

    int checks = 0;
    int errors = 0;
    int last_wait;
    logic [12:0] sb[$];

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Zero(Zero), .Carry(Carry), .Neg(Neg), .Ovf(Ovf), .Err(Err)
    );

    always #5 clk = ~clk;

    // {Result, Zero, Carry, Neg, Ovf, Err}
    function automatic logic [12:0] mk(input logic [7:0] r, input logic z, c, n, v, e);
        return {r, z, c, n, v, e};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(Result), 32'hFFFF_FFFF);
            end else begin
                logic [12:0] e;
                e = sb.pop_front();
                check("result_flags", 32'({Result, Zero, Carry, Neg, Ovf, Err}), 32'(e));
            end
        end
    end

    task automatic issue(input logic [7:0] a, b, input logic [3:0] op,
                         input logic [12:0] e, input bit push);
        int   n;
        logic acc;
        A = a; B = b; ALUOp = op; in_valid = 1'b1;
        if (push) sb.push_back(e);
        n = 0; acc = 1'b0;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        A = 8'($urandom); B = 8'($urandom); ALUOp = 4'($urandom);
        last_wait = n;
        if (!acc) check("accept_timeout", 32'(n), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        A = 8'h11; B = 8'h22; ALUOp = 4'd0;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("rst_outputs", 32'({Result, Zero, Carry, Neg, Ovf, Err}), 32'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        issue(8'hFF, 8'h01, 4'd0, mk(8'h00, 1, 1, 0, 0, 0), 1);
        check("add_latency", 32'(out_valid), 32'd1);
        issue(8'h80, 8'h01, 4'd1, mk(8'h7F, 0, 0, 0, 1, 0), 1);
        issue(8'h81, 8'h09, 4'd6, mk(8'h02, 0, 1, 0, 0, 0), 1);
        issue(8'hF0, 8'h3C, 4'd2, mk(8'h30, 0, 0, 0, 0, 0), 1);
        issue(8'hF0, 8'h0F, 4'd3, mk(8'hFF, 0, 0, 1, 0, 0), 1);
        issue(8'hAA, 8'hFF, 4'd4, mk(8'h55, 0, 0, 0, 0, 0), 1);
        issue(8'h0F, 8'h00, 4'd5, mk(8'hF0, 0, 0, 1, 0, 0), 1);
        issue(8'h81, 8'h01, 4'd7, mk(8'h40, 0, 1, 0, 0, 0), 1);
        issue(8'h81, 8'h01, 4'd8, mk(8'hC0, 0, 1, 1, 0, 0), 1);
        issue(8'h5A, 8'h08, 4'd6, mk(8'h5A, 0, 0, 0, 0, 0), 1);
        issue(8'h7F, 8'h01, 4'd0, mk(8'h80, 0, 0, 1, 1, 0), 1);
        issue(8'h00, 8'h01, 4'd1, mk(8'hFF, 0, 1, 1, 0, 0), 1);
        issue(8'h05, 8'h05, 4'd1, mk(8'h00, 1, 0, 0, 0, 0), 1);
        issue(8'h12, 8'h34, 4'hC, mk(8'h00, 1, 0, 0, 0, 1), 1);

`ifdef ALU_PIPE_MUL_EN
        issue(8'h0F, 8'h11, 4'd9, mk(8'hFF, 0, 0, 1, 0, 0), 1);
        for (int k = 1; k <= 8; k++) begin
            check("mul_busy_valid", 32'(out_valid), 32'd0);
            check("mul_busy_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check("mul_latency", 32'(out_valid), 32'd1);
        issue(8'h10, 8'h10, 4'd9, mk(8'h00, 1, 1, 0, 0, 0), 1);
        repeat (8) tick();
`else
        issue(8'h03, 8'h04, 4'd9, mk(8'h00, 1, 0, 0, 0, 1), 1);
        check("op9_latency", 32'(out_valid), 32'd1);
`endif
        tick();

        out_ready = 1'b0;
        issue(8'h12, 8'h34, 4'd0, mk(8'h46, 0, 0, 0, 0, 0), 1);
        for (int k = 0; k < 5; k++) begin
            A = 8'($urandom); B = 8'($urandom);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_result", 32'({Result, Zero, Carry, Neg, Ovf, Err}), 32'(mk(8'h46, 0, 0, 0, 0, 0)));
            tick();
        end
        out_ready = 1'b1;
        issue(8'h01, 8'h02, 4'd0, mk(8'h03, 0, 0, 0, 0, 0), 1);
        check("stream_wait0", 32'(last_wait), 32'd1);
        issue(8'h10, 8'h20, 4'd0, mk(8'h30, 0, 0, 0, 0, 0), 1);
        check("stream_wait1", 32'(last_wait), 32'd1);
        issue(8'h40, 8'h40, 4'd0, mk(8'h80, 0, 0, 1, 1, 0), 1);
        check("stream_wait2", 32'(last_wait), 32'd1);
        issue(8'hFF, 8'hFF, 4'd0, mk(8'hFE, 0, 1, 1, 0, 0), 1);
        check("stream_wait3", 32'(last_wait), 32'd1);
        check("stream_valid", 32'(out_valid), 32'd1);
        tick();
        check("idle_after_drain", 32'(out_valid), 32'd0);

`ifdef ALU_PIPE_MUL_EN
        issue(8'h0F, 8'h11, 4'd9, 13'd0, 0);
        repeat (3) tick();
`else
        out_ready = 1'b0;
        issue(8'h01, 8'h01, 4'd0, 13'd0, 0);
`endif
        rst = 1'b1;
        #1;
        check("rst_prio_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_outputs", 32'({Result, Zero, Carry, Neg, Ovf, Err}), 32'd0);
        check("rst_mid_idle", 32'(in_ready), 32'd1);
        issue(8'h03, 8'h04, 4'd0, mk(8'h07, 0, 0, 0, 0, 0), 1);
        issue(8'h03, 8'h04, 4'hC, mk(8'h00, 1, 0, 0, 0, 1), 1);

        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand/result width in bits; legal range 4..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports in_valid input 1 (request present), in_ready output 1 (request accepted when both are high).
REQ-005 SHALL have ports A input WIDTH, B input WIDTH, ALUOp input 4 (operation code).
REQ-006 SHALL have ports out_valid output 1 (result present) and out_ready input 1 (consumer takes result when both are high).
REQ-007 SHALL have ports Result output WIDTH, Zero/Carry/Neg/Ovf output 1 each (flags), Err output 1 (undefined opcode).

Function
REQ-008 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-009 in_ready SHALL be high in IDLE, and also in DONE while out_ready is high; it SHALL be low in BUSY.
REQ-010 SHALL capture A, B and ALUOp on the accept cycle only; input changes while not accepting SHALL be ignored.
REQ-011 For a single-cycle op accepted in cycle T, out_valid SHALL be high in cycle T+1 (state DONE).
REQ-012 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL, 7 SHR logical, 8 SAR arithmetic, 9 MUL (low WIDTH bits of A*B).
REQ-013 Shift amount SHALL be B mod WIDTH; a shift by 0 SHALL return A with Carry=0.
REQ-014 MUL SHALL be iterative shift-add, one multiplier bit per cycle, in BUSY for WIDTH cycles; out_valid SHALL be high in cycle T+WIDTH+1.
REQ-015 Zero SHALL equal (Result==0) for every op, and Neg SHALL equal Result[WIDTH-1].
REQ-016 Carry: ADD carry-out; SUB borrow (A<B unsigned); SHL/SHR/SAR the last bit shifted out; MUL set if the high half of the 2*WIDTH product is nonzero; 0 otherwise.
REQ-017 Ovf SHALL be signed overflow for ADD/SUB and 0 for all other ops.
REQ-018 Opcodes 10..15 SHALL complete as single-cycle ops with Result=0, Zero=1, Carry=Neg=Ovf=0, Err=1; Err SHALL be 0 for defined opcodes.
REQ-019 In DONE with out_ready low, Result, flags and Err SHALL hold stable and out_valid SHALL stay high.
REQ-020 In DONE with out_ready high: if in_valid is high, the new request SHALL be accepted in the same cycle (back-to-back, one single-cycle result per clock); otherwise the FSM SHALL go to IDLE and out_valid SHALL fall.
REQ-021 out_valid SHALL never be high in IDLE or BUSY.

Reset
REQ-022 On rst high at a clock edge: state=IDLE, out_valid=0, Result=0, Zero=Carry=Neg=Ovf=Err=0, and any MUL in progress SHALL be discarded.
REQ-023 While rst is high, in_ready SHALL be low and no request SHALL be accepted; rst SHALL take priority over all other events.

Configuration
REQ-024 Macro ALU_PIPE_MUL_EN: when defined, opcode 9 SHALL be MUL per REQ-014/016.
REQ-025 When ALU_PIPE_MUL_EN is undefined, no multiplier logic SHALL be built, BUSY SHALL be unreachable, and opcode 9 SHALL behave as undefined per REQ-018.

Verification (WIDTH=8)
REQ-026 ADD A=8'hFF B=8'h01 -> Result 8'h00, Zero=1, Carry=1, Ovf=0, out_valid one cycle after accept.
REQ-027 SUB A=8'h80 B=8'h01 -> Result 8'h7F, Ovf=1, Carry=0, Neg=0; SHL A=8'h81 B=8'h09 -> Result 8'h02, Carry=1.
REQ-028 MUL (MUL_EN) A=8'h0F B=8'h11 -> 8'hFF, Carry=0, out_valid exactly 9 cycles after accept; A=8'h10 B=8'h10 -> 8'h00, Zero=1, Carry=1; in_ready low throughout BUSY.
REQ-029 out_ready held low 5 cycles in DONE -> Result/flags stable, in_ready=0; then out_ready=1 with in_valid=1 streams 4 ADDs with one result per cycle.
REQ-030 rst asserted 4 cycles into a MUL -> next cycle IDLE, out_valid=0, all outputs 0; a following ADD 3+4 -> 8'h07; opcode 4'hC -> Result 0, Err=1, Zero=1; without MUL_EN, opcode 9 -> Err=1 after 1 cycle.
